// File: rtl/inst_encoder_loader_pkg.sv
// rtl/inst_encoder_loader_pkg.sv - shared field ranges, format tags and state encodings
// Bit ranges follow the MIPS R/I/J layouts; the format tag selects which fields are packed.
package inst_encoder_loader_pkg;

   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int SHAM_HI  = 10;
   localparam int SHAM_LO  = 6;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;
   localparam int IMM16_HI = 15;
   localparam int IMM16_LO = 0;
   localparam int IMM26_HI = 25;
   localparam int IMM26_LO = 0;

   localparam logic [1:0] FMT_R = 2'b00;
   localparam logic [1:0] FMT_I = 2'b01;
   localparam logic [1:0] FMT_J = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/inst_pack.sv
// rtl/inst_pack.sv - combinational R/I/J instruction packer
// Fields not used by the selected format are ignored; fmt 11 yields legal = 0 and a zero word.
module inst_pack
   import inst_encoder_loader_pkg::*;
(
   input  logic [1:0]  fmt,
   input  logic [5:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  sham,
   input  logic [5:0]  funct,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   output logic [31:0] word,
   output logic        legal
);

   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (fmt)
         FMT_R: begin
            word[OP_HI:OP_LO]       = op;
            word[RS_HI:RS_LO]       = rs;
            word[RT_HI:RT_LO]       = rt;
            word[RD_HI:RD_LO]       = rd;
            word[SHAM_HI:SHAM_LO]   = sham;
            word[FUNCT_HI:FUNCT_LO] = funct;
         end
         FMT_I: begin
            word[OP_HI:OP_LO]       = op;
            word[RS_HI:RS_LO]       = rs;
            word[RT_HI:RT_LO]       = rt;
            word[IMM16_HI:IMM16_LO] = imm16;
         end
         FMT_J: begin
            word[OP_HI:OP_LO]       = op;
            word[IMM26_HI:IMM26_LO] = imm26;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - encodes field bundles and loads them sequentially into instruction RAM
// One registered write per legal bundle; session tracks word count, XOR checksum and illegal-format status.
module inst_encoder_loader
   import inst_encoder_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  finish,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            fmt,
   input  logic [5:0]            op,
   input  logic [4:0]            rs,
   input  logic [4:0]            rt,
   input  logic [4:0]            rd,
   input  logic [4:0]            sham,
   input  logic [5:0]            funct,
   input  logic [15:0]           imm16,
   input  logic [25:0]           imm26,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]           wr_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic [31:0]           checksum,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] ptr_q;
   logic [ADDR_WIDTH:0]   count_q;
   logic [31:0]           checksum_q;
   logic                  err_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  wr_en_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [31:0]           wr_data_q;

   logic [31:0]           packed_word;
   logic                  packed_legal;
   logic                  accept;
   logic                  write;

   inst_pack u_pack (
      .fmt   (fmt),
      .op    (op),
      .rs    (rs),
      .rt    (rt),
      .rd    (rd),
      .sham  (sham),
      .funct (funct),
      .imm16 (imm16),
      .imm26 (imm26),
      .word  (packed_word),
      .legal (packed_legal)
   );

   assign accept = in_valid & in_ready;
   assign write  = accept & packed_legal;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // start outranks finish; a legal write at the last address closes the session so the pointer never wraps
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (start) begin
               state_d = ST_LOAD;
            end else if (finish || (write && (ptr_q == LAST_ADDR))) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) state_d = ST_LOAD;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      in_ready = (state_q == ST_LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= (state_d == ST_LOAD);
         done_q <= (state_d == ST_DONE);
      end
   end

   // A bundle accepted alongside start is still written at the old pointer; the session clear lands on top.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         ptr_q      <= '0;
         count_q    <= '0;
         checksum_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wr_en_q <= write;
         if (write) begin
            wr_addr_q <= ptr_q;
            wr_data_q <= packed_word;
         end
         if (start) begin
            ptr_q      <= '0;
            count_q    <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
         end else begin
            if (write) begin
               ptr_q      <= ptr_q + 1'b1;
               count_q    <= count_q + 1'b1;
               checksum_q <= checksum_q ^ packed_word;
            end
            if (accept && !packed_legal) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign count    = count_q;
   assign checksum = checksum_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule
